// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache answering fetch requests.
// Hits respond the cycle after accept; misses refill a whole line from memory, critical word captured on the way.
module icache_responder #(
    parameter int ADDR_W     = 32,
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_rsp_valid,
    output logic [31:0]       ic_rsp_data,
    input  logic              kill_i,
    input  logic              fence_i,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_LSB = IDX_W + OFF_W + 2;
    localparam int TAG_W   = ADDR_W - TAG_LSB;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_RESPOND
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 kill_q, kill_d;
    logic                 fence_pend_q, fence_pend_d;
    logic [OFF_W-1:0]     beat_q, beat_d;
    logic [31:0]          crit_q, crit_d;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             inv_all;
    logic             install;
    logic             beat_we;

    // The request being served is always the one latched in addr_q.
    assign off = addr_q[OFF_W+1:2];
    assign idx = addr_q[TAG_LSB-1:OFF_W+2];
    assign tag = addr_q[ADDR_W-1:TAG_LSB];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        kill_d        = kill_q;
        fence_pend_d  = fence_pend_q;
        beat_d        = beat_q;
        crit_d        = crit_q;
        ic_req_ready  = 1'b0;
        ic_rsp_valid  = 1'b0;
        ic_rsp_data   = 32'h0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        inv_all       = 1'b0;
        install       = 1'b0;
        beat_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                ic_req_ready = !fence_pend_q && !fence_i;
                kill_d       = 1'b0;
                if (fence_i || fence_pend_q) begin
                    inv_all      = 1'b1;
                    fence_pend_d = 1'b0;
                end
                if (ic_req_valid && ic_req_ready) begin
                    addr_d  = ic_req_addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (fence_i) fence_pend_d = 1'b1;
                if (kill_i) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    ic_rsp_valid = 1'b1;
                    ic_rsp_data  = data_q[idx][off];
                    ic_req_ready = !fence_pend_q;
                    if (ic_req_valid && ic_req_ready) begin
                        addr_d  = ic_req_addr;
                        state_d = S_LOOKUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                if (fence_i) fence_pend_d = 1'b1;
                if (kill_i) kill_d = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q & LINE_MASK;
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = S_REFILL_WAIT;
                end
            end
            S_REFILL_WAIT: begin
                if (fence_i) fence_pend_d = 1'b1;
                if (kill_i) kill_d = 1'b1;
                if (mem_rsp_valid) begin
                    beat_we = 1'b1;
                    beat_d  = beat_q + OFF_W'(1);
                    if (beat_q == off) crit_d = mem_rsp_data;
                    if (beat_q == LAST_BEAT) begin
                        install = 1'b1;
                        state_d = S_RESPOND;
                    end
                end
            end
            S_RESPOND: begin
                if (fence_i) fence_pend_d = 1'b1;
                ic_rsp_valid = !kill_q;
                ic_rsp_data  = kill_q ? 32'h0 : crit_q;
                kill_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs and array writes stay quiet while reset is asserted.
        if (rst_i) begin
            ic_req_ready  = 1'b0;
            ic_rsp_valid  = 1'b0;
            ic_rsp_data   = 32'h0;
            mem_req_valid = 1'b0;
            mem_req_addr  = '0;
            inv_all       = 1'b0;
            install       = 1'b0;
            beat_we       = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            kill_q       <= 1'b0;
            fence_pend_q <= 1'b0;
            beat_q       <= '0;
            crit_q       <= 32'h0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            kill_q       <= kill_d;
            fence_pend_q <= fence_pend_d;
            beat_q       <= beat_d;
            crit_q       <= crit_d;
            if (inv_all) valid_q <= '0;
            else if (install) valid_q[idx] <= 1'b1;
        end
    end

    // Tag and data storage need no reset; the valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (install) tag_q[idx] <= tag;
        if (beat_we) data_q[idx][beat_q] <= mem_rsp_data;
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed table-driven bench for icache_responder: every row is one clock cycle of inputs and expected outputs.
module tb_icache_responder;

    typedef struct {
        logic        rst;
        logic        reqValid;
        logic [31:0] reqAddr;
        logic        kill;
        logic        fence;
        logic        memReqReady;
        logic        memRspValid;
        logic [31:0] memRspData;
        logic        expReady;
        logic        expRspValid;
        logic [31:0] expRspData;
        logic        expMemValid;
        logic [31:0] expMemAddr;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ic_req_valid;
    logic        ic_req_ready;
    logic [31:0] ic_req_addr;
    logic        ic_rsp_valid;
    logic [31:0] ic_rsp_data;
    logic        kill_i;
    logic        fence_i;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int checks = 0;
    int errors = 0;

    icache_responder dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ic_req_valid  (ic_req_valid),
        .ic_req_ready  (ic_req_ready),
        .ic_req_addr   (ic_req_addr),
        .ic_rsp_valid  (ic_rsp_valid),
        .ic_rsp_data   (ic_rsp_data),
        .kill_i        (kill_i),
        .fence_i       (fence_i),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic rst, input logic rv, input logic [31:0] ra,
                                input logic kl, input logic fn, input logic mrr,
                                input logic mrv, input logic [31:0] mrd,
                                input logic eRdy, input logic eRv, input logic [31:0] eRd,
                                input logic eMv, input logic [31:0] eMa);
        vec_t v;
        v.rst = rst;          v.reqValid = rv;      v.reqAddr = ra;
        v.kill = kl;          v.fence = fn;         v.memReqReady = mrr;
        v.memRspValid = mrv;  v.memRspData = mrd;
        v.expReady = eRdy;    v.expRspValid = eRv;  v.expRspData = eRd;
        v.expMemValid = eMv;  v.expMemAddr = eMa;
        return v;
    endfunction

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk_i);
        #1;
        rst_i         = v.rst;
        ic_req_valid  = v.reqValid;
        ic_req_addr   = v.reqAddr;
        kill_i        = v.kill;
        fence_i       = v.fence;
        mem_req_ready = v.memReqReady;
        mem_rsp_valid = v.memRspValid;
        mem_rsp_data  = v.memRspData;
        @(negedge clk_i);
    endtask

    task automatic compare(input string tag, input string sig, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", tag, sig, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        compare(tag, "ic_req_ready", {31'h0, ic_req_ready}, {31'h0, v.expReady});
        compare(tag, "ic_rsp_valid", {31'h0, ic_rsp_valid}, {31'h0, v.expRspValid});
        compare(tag, "mem_req_valid", {31'h0, mem_req_valid}, {31'h0, v.expMemValid});
        if (v.expRspValid || v.rst) compare(tag, "ic_rsp_data", ic_rsp_data, v.expRspData);
        if (v.expMemValid || v.rst) compare(tag, "mem_req_addr", mem_req_addr, v.expMemAddr);
    endtask

    task automatic runSeq(input string name, input vec_t seq[$]);
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            checkOutput($sformatf("%s%0d", name, i), seq[i]);
        end
    endtask

    // Beats of a full line, expected outputs all idle.
    task automatic pushBeats(inout vec_t q[$], input logic [31:0] base);
        for (int b = 0; b < 4; b++)
            q.push_back(mk(0,0,0,0,0,0,1,base + 32'(b), 0,0,0,0,0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        vec_t tbl[$];
        vec_t seq[$];

        rst_i = 1'b1; ic_req_valid = 1'b0; ic_req_addr = 32'h0; kill_i = 1'b0;
        fence_i = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;

        // Reset, cold miss on 0x104 with a gap between beats, then back-to-back hits.
        tbl.push_back(mk(1,0,0,0,0,0,0,0,          0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,          0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,          1,0,0,0,0));
        tbl.push_back(mk(0,1,'h104,0,0,0,0,0,      1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,1,'h100));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,          0,0,0,1,'h100));
        tbl.push_back(mk(0,0,0,0,0,0,1,'hA0,       0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,'hA1,       0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,'hA2,       0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,'hA3,       0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,          0,1,'hA1,0,0));
        tbl.push_back(mk(0,1,'h100,0,0,0,0,0,      1,0,0,0,0));
        tbl.push_back(mk(0,1,'h108,0,0,0,0,0,      1,1,'hA0,0,0));
        tbl.push_back(mk(0,1,'h10C,0,0,0,0,0,      1,1,'hA2,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,          1,1,'hA3,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,'hFF,       1,0,0,0,0));
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("tbl%0d", i), tbl[i]);
        end

        // Conflict: 0x500 evicts 0x100, then 0x100 misses again and is restored.
        seq.delete();
        seq.push_back(mk(0,1,'h500,0,0,0,0,0,      1,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,1,0,0,          0,0,0,1,'h500));
        pushBeats(seq, 32'hB0);
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,1,'hB0,0,0));
        seq.push_back(mk(0,1,'h100,0,0,0,0,0,      1,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,1,0,0,          0,0,0,1,'h100));
        pushBeats(seq, 32'hA0);
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,1,'hA0,0,0));
        runSeq("conflict", seq);

        // Kill after beat 1: no response, but the line is installed and then hits.
        seq.delete();
        seq.push_back(mk(0,1,'h204,0,0,0,0,0,      1,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,1,0,0,          0,0,0,1,'h200));
        seq.push_back(mk(0,0,0,0,0,0,1,'hC0,       0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,1,'hC1,       0,0,0,0,0));
        seq.push_back(mk(0,0,0,1,0,0,0,0,          0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,1,'hC2,       0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,1,'hC3,       0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0));
        seq.push_back(mk(0,1,'h204,0,0,0,0,0,      1,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          1,1,'hC1,0,0));
        runSeq("kill", seq);

        // Fence in IDLE blocks that cycle's request and invalidates 0x100.
        seq.delete();
        seq.push_back(mk(0,1,'h100,0,1,0,0,0,      0,0,0,0,0));
        seq.push_back(mk(0,1,'h100,0,0,0,0,0,      1,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,1,0,0,          0,0,0,1,'h100));
        pushBeats(seq, 32'hA0);
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,1,'hA0,0,0));
        runSeq("fenceIdle", seq);

        // Fence mid-refill: response still given, line invalid afterwards; then reset mid-refill.
        seq.delete();
        seq.push_back(mk(0,1,'h300,0,0,0,0,0,      1,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,1,0,0,          0,0,0,1,'h300));
        seq.push_back(mk(0,0,0,0,1,0,1,'hD0,       0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,1,'hD1,       0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,1,'hD2,       0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,1,'hD3,       0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,1,'hD0,0,0));
        seq.push_back(mk(0,1,'h300,0,0,0,0,0,      0,0,0,0,0));
        seq.push_back(mk(0,1,'h300,0,0,0,0,0,      1,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,1,'h300));
        seq.push_back(mk(0,0,0,0,0,1,0,0,          0,0,0,1,'h300));
        seq.push_back(mk(0,0,0,0,0,0,1,'hE0,       0,0,0,0,0));
        seq.push_back(mk(1,0,0,0,0,0,0,0,          0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,1,'hE1,       1,0,0,0,0));
        seq.push_back(mk(0,1,'h104,0,0,0,0,0,      1,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,          0,0,0,1,'h100));
        runSeq("fenceRefill", seq);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
